// File: rtl/ifetch_ctrl.sv
// Fetch sequencer driving the PC register; one instruction per 2 cycles with a zero-wait memory (ack -> inst_valid next cycle).
// Decode backpressure holds the buffered word in OUT; a redirect preempts everything and discards any in-flight word.
module ifetch_ctrl #(
   parameter int INST_BYTES = 4
) (
   input  logic        clk_in,
   input  logic        clk_rst,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_next,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        err_misalign,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] LP_INC = 32'(INST_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_load;
   logic        w_consume;
   logic [31:0] w_redirect_tgt;

   logic        r_inst_valid;
   logic [31:0] r_inst_out;
   logic [31:0] r_inst_pc;
   logic        r_err_misalign;
   logic [31:0] r_fetch_count;

   assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign mem_addr       = pc_cur;

   always_comb begin
      w_state_nxt = r_state;
      pc_next     = pc_cur;
      mem_req     = 1'b0;
      w_load      = 1'b0;
      w_consume   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               pc_next     = pc_cur + LP_INC;
               w_load      = 1'b1;
               w_state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (inst_ready) begin
               w_consume   = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Redirect wins over ack; a handshake in the same cycle still counts.
      if (redirect_valid) begin
         pc_next     = w_redirect_tgt;
         w_state_nxt = ST_FETCH;
         w_load      = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge clk_rst) begin
      if (!clk_rst) begin
         r_state        <= ST_IDLE;
         r_inst_valid   <= 1'b0;
         r_inst_out     <= 32'd0;
         r_inst_pc      <= 32'd0;
         r_err_misalign <= 1'b0;
         r_fetch_count  <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_inst_valid <= (w_state_nxt == ST_OUT);
         if (w_load) begin
            r_inst_out <= mem_rdata;
            r_inst_pc  <= pc_cur;
         end
         if (w_consume) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_err_misalign <= 1'b1;
         end
      end
   end

   assign inst_valid   = r_inst_valid;
   assign inst_out     = r_inst_out;
   assign inst_pc      = r_inst_pc;
   assign err_misalign = r_err_misalign;
   assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: models the external PC register and checks against a buffer-level reference model.
module tb_ifetch_ctrl;

   logic        clk_in;
   logic        clk_rst;
   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        err_misalign;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   // Reference model: "started" (past the post-reset idle cycle), a one-entry buffer, PC, counters.
   bit          m_started;
   bit          m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_ipc;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   bit          m_err;

   ifetch_ctrl #(.INST_BYTES(4)) dut (
      .clk_in         (clk_in),
      .clk_rst        (clk_rst),
      .pc_cur         (pc_reg),
      .pc_next        (pc_next),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .err_misalign   (err_misalign),
      .fetch_count    (fetch_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in or negedge clk_rst) begin
      if (!clk_rst) pc_reg <= 32'd0;
      else          pc_reg <= pc_next;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0;
      m_valid   = 0;
      m_inst    = 32'd0;
      m_ipc     = 32'd0;
      m_pc      = 32'd0;
      m_cnt     = 32'd0;
      m_err     = 0;
   endtask

   task automatic chk_regs();
      chk("pc_reg",       pc_reg,               m_pc);
      chk("inst_valid",   32'(inst_valid),      32'(m_valid));
      chk("inst_out",     inst_out,             m_inst);
      chk("inst_pc",      inst_pc,              m_ipc);
      chk("err_misalign", 32'(err_misalign),    32'(m_err));
      chk("fetch_count",  fetch_count,          m_cnt);
   endtask

   // One clock cycle: drive inputs at the falling edge, check mid-cycle, advance the model on the rising edge.
   task automatic cyc(input logic ack, input logic [31:0] rdata, input logic rdy,
                      input logic rv, input logic [31:0] rpc);
      logic        exp_req;
      logic [31:0] exp_next;
      logic [31:0] tgt;
      mem_ack        = ack;
      mem_rdata      = rdata;
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      tgt     = {rpc[31:2], 2'b00};
      exp_req = m_started && !m_valid;
      if (rv)                 exp_next = tgt;
      else if (exp_req && ack) exp_next = m_pc + 32'd4;
      else                    exp_next = m_pc;
      chk("mem_req",  32'(mem_req), 32'(exp_req));
      chk("mem_addr", mem_addr,     m_pc);
      chk("pc_next",  pc_next,      exp_next);
      chk_regs();
      @(posedge clk_in);
      if (rv) begin
         if (m_valid && rdy) m_cnt = m_cnt + 32'd1;
         m_valid   = 0;
         m_started = 1;
         if (rpc[1:0] != 2'b00) m_err = 1;
         m_pc = tgt;
      end else if (!m_started) begin
         m_started = 1;
      end else if (!m_valid) begin
         if (ack) begin
            m_valid = 1;
            m_inst  = rdata;
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
         end
      end else if (rdy) begin
         m_cnt   = m_cnt + 32'd1;
         m_valid = 0;
      end
      @(negedge clk_in);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] saved_pc;
      logic [31:0] saved_ipc;
      logic        ack;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;

      clk_rst        = 1'b0;
      mem_ack        = 1'b0;
      mem_rdata      = 32'd0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      model_reset();
      #2;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk_regs();
      @(negedge clk_in);
      clk_rst = 1'b1;

      // Zero-wait memory, decode always ready.
      cyc(1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'd0);
      chk("first_req",  32'(mem_req), 32'd1);
      chk("first_addr", mem_addr, 32'd0);
      cyc(1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'd0);
      chk("first_valid", 32'(inst_valid), 32'd1);
      chk("first_ipc",   inst_pc, 32'd0);
      chk("first_inst",  inst_out, 32'h0010_0093);
      chk("next_addr",   mem_addr, 32'd4);
      cyc(1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'd0);
      chk("first_count", fetch_count, 32'd1);
      chk("refetch_req", 32'(mem_req), 32'd1);

      // Three wait states, then decode stalls for four cycles while stray acks are ignored.
      saved_pc = pc_reg;
      repeat (3) cyc(1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 32'd0);
      w = $urandom;
      cyc(1'b1, w, 1'b0, 1'b0, 32'd0);
      repeat (4) cyc(1'b1, ~w, 1'b0, 1'b0, 32'd0);
      chk("stall_inst", inst_out, w);
      chk("stall_ipc",  inst_pc, saved_pc);
      chk("stall_pc",   pc_reg, saved_pc + 32'd4);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      // Redirect coincident with an ack in FETCH discards the word.
      saved_ipc = inst_pc;
      cyc(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 32'h0000_0040);
      chk("rd_fetch_valid", 32'(inst_valid), 32'd0);
      chk("rd_fetch_addr",  mem_addr, 32'h40);
      chk("rd_fetch_ipc",   inst_pc, saved_ipc);

      // Misaligned redirect while a word is buffered.
      cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
      chk("out_valid", 32'(inst_valid), 32'd1);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0082);
      chk("rd_out_valid", 32'(inst_valid), 32'd0);
      chk("rd_out_addr",  mem_addr, 32'h80);
      chk("rd_out_err",   32'(err_misalign), 32'd1);
      chk("rd_out_count", fetch_count, m_cnt);

      // PC wrap at the top of the address space.
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      cyc(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0);
      chk("wrap_ipc",  inst_pc, 32'hFFFF_FFFC);
      chk("wrap_addr", mem_addr, 32'd0);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      // Randomized traffic with wait states, stalls and occasional redirects.
      for (int i = 0; i < 400; i++) begin
         ack = ($urandom_range(0, 99) < 55);
         rdy = ($urandom_range(0, 99) < 60);
         rv  = ($urandom_range(0, 99) < 8);
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         cyc(ack, $urandom, rdy, rv, rpc);
      end

      // Asynchronous reset while a word is buffered.
      while (!m_valid) cyc(1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'd0);
      if (!m_err) cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0101);
      while (!m_valid) cyc(1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'd0);
      chk("pre_rst_valid", 32'(inst_valid), 32'd1);
      #2;
      clk_rst = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", 32'(inst_valid), 32'd0);
      chk("arst_count", fetch_count, 32'd0);
      chk("arst_err",   32'(err_misalign), 32'd0);
      chk("arst_req",   32'(mem_req), 32'd0);
      chk("arst_pc",    pc_reg, 32'd0);
      @(negedge clk_in);
      @(negedge clk_in);
      clk_rst = 1'b1;
      cyc(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'd0);
      chk("restart_req",  32'(mem_req), 32'd1);
      chk("restart_addr", mem_addr, 32'd0);
      repeat (4) cyc(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sits directly upstream of the 32-bit PC register. It drives the register's `data_in` every cycle and reads back its `data_out`. It sequences instruction-memory requests at the current PC, buffers the returned word, and presents it to decode through a valid/ready handshake. It also applies branch/jump redirects, since the PC register has no enable and loads `pc_next` on every `clk_in` rising edge.

## Interface
Parameters:
- `INST_BYTES`, default 4: PC increment per delivered instruction.

Ports:
- `clk_in`, input, 1: clock. Rising edge.
- `clk_rst`, input, 1: reset. Asynchronous, active-low.
- `pc_cur`, input, 32: current PC, from the PC register `data_out`.
- `pc_next`, output, 32: next PC, to the PC register `data_in`. Combinational.
- `mem_req`, output, 1: instruction-memory request.
- `mem_addr`, output, 32: fetch address. Equals `pc_cur`.
- `mem_ack`, input, 1: memory returns `mem_rdata` this cycle. Only meaningful while `mem_req`=1.
- `mem_rdata`, input, 32: instruction word.
- `inst_valid`, output, 1: buffered instruction available to decode.
- `inst_out`, output, 32: buffered instruction.
- `inst_pc`, output, 32: PC of `inst_out`.
- `inst_ready`, input, 1: decode accepts `inst_out`.
- `redirect_valid`, input, 1: branch/jump taken.
- `redirect_pc`, input, 32: redirect target.
- `err_misalign`, output, 1: sticky flag; a redirect target had `[1:0]`≠0.
- `fetch_count`, output, 32: number of instructions accepted by decode. Wraps modulo 2^32.

## Operation
- FSM states: IDLE, FETCH, OUT.
- Reset (async, `clk_rst`=0):
  - state=IDLE.
  - `inst_valid`=0, `inst_out`=0, `inst_pc`=0, `err_misalign`=0, `fetch_count`=0.
  - `mem_req`=0.
  - The PC register resets to 0 on the same signal.
- IDLE: `mem_req`=0, `pc_next`=`pc_cur`. Moves to FETCH on the next edge unconditionally.
- FETCH:
  - `mem_req`=1, `mem_addr`=`pc_cur`.
  - No ack: `pc_next`=`pc_cur`, stay in FETCH.
  - `mem_ack`=1: on the edge, `inst_out`←`mem_rdata` and `inst_pc`←`pc_cur`. `pc_next`=`pc_cur`+`INST_BYTES`. Go to OUT.
- OUT:
  - `mem_req`=0, `inst_valid`=1, `pc_next`=`pc_cur`.
  - `inst_valid`&`inst_ready`: `fetch_count`+1, go to FETCH.
  - Otherwise hold `inst_out` and `inst_pc` stable.
- `inst_valid` is a registered decode of state==OUT. It never drops without a handshake except on redirect.
- Redirect (`redirect_valid`=1) has the highest priority in any state:
  - `pc_next`={`redirect_pc[31:2]`,2'b00}.
  - Next state is FETCH.
  - In FETCH with a simultaneous `mem_ack`: the returned word is discarded, `inst_out` and `inst_pc` are not loaded.
  - In OUT: the buffered instruction is dropped. `inst_valid`=0 next cycle. `fetch_count` increments only if `inst_ready` was also 1 that cycle, because decode consumed the instruction.
  - If `redirect_pc[1:0]`≠0, `err_misalign`←1. Cleared only by reset.
- Arithmetic: `pc_cur`+`INST_BYTES` is mod 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Memory protocol:
  - `mem_addr` may change while `mem_req`=1 without an ack (only after a redirect).
  - Memory samples the address in the ack cycle.
  - `mem_ack` while `mem_req`=0 is ignored.

## Timing
- `pc_next`, `mem_req` and `mem_addr` are combinational from state, `pc_cur`, `mem_ack` and the redirect inputs. All other outputs are registered.
- First request: reset release, then IDLE for 1 cycle. `mem_req`=1 in cycle 2 after release.
- Ack in cycle t gives `inst_valid`=1 in t+1, with PC register = old+4 in t+1.
- Handshake in t+1 gives `mem_req`=1 in t+2.
- Peak throughput: one instruction per 2 cycles with a zero-wait memory.
- Memory wait states extend FETCH by one cycle each. No timeout.
- Redirect in cycle t: PC register = target in t+1, `mem_req`=1 at target in t+1.
- Reset asserted mid-FETCH or mid-OUT: all registers clear immediately (asynchronously). The pending memory transaction is abandoned.

## Test plan
- Reset release, `mem_ack` held 1, `mem_rdata`=32'h0010_0093, `inst_ready`=1:
  - `mem_req` first rises in cycle 2 with `mem_addr`=0.
  - `inst_valid` in cycle 3 with `inst_pc`=0.
  - Next `mem_addr`=4. `fetch_count`=1.
- Memory with 3 wait states and `inst_ready` held 0 for 4 cycles: `mem_req` stays high 4 cycles, then `inst_out`/`inst_pc` are stable and `inst_valid`=1 for 4 cycles. The PC register advances exactly once.
- Redirect to 32'h0000_0040 in the same cycle as `mem_ack` in FETCH: word discarded, `inst_valid` stays 0, next `mem_addr`=32'h40.
- Redirect to 32'h0000_0082 while in OUT: `inst_valid` drops, `mem_addr`=32'h80, `err_misalign`=1 until reset.
- PC register at 32'hFFFF_FFFC, one fetch: `inst_pc`=32'hFFFF_FFFC, next `mem_addr`=0.
- `clk_rst` pulsed low mid-OUT: `inst_valid`, `fetch_count` and `err_misalign` go to 0 without a clock edge. The fetch sequence restarts from address 0.
